// File: rtl/regfile_nport.sv
// Parametrised register file: one write port and NREAD registered read ports with valid flags.
// Optional hard-wired zero register and optional same-edge write-to-read bypass.
module regfile_nport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_valid
);

    // One extra bit so that a power-of-two DEPTH is representable for range checks.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_in_range_s;
    logic             wr_legal_s;

    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
    assign wr_legal_s    = wr_en & wr_in_range_s & ~(ZERO_REG & (wr_addr == {ADDR_W{1'b0}}));

    // Storage array: cleared on reset, updated only by legal writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
        end else if (wr_legal_s) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              in_range_s;
        logic [WIDTH-1:0]  data_d;
        logic [WIDTH-1:0]  data_q;
        logic              valid_d;
        logic              valid_q;

        assign addr_s     = rd_addr[i*ADDR_W +: ADDR_W];
        assign in_range_s = ({1'b0, addr_s} < DEPTH_C);

        // Read source priority: zero register, out of range, bypassed write, stored word.
        always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            if (rd_en[i]) begin
                valid_d = 1'b1;
                if (ZERO_REG && (addr_s == {ADDR_W{1'b0}})) begin
                    data_d = {WIDTH{1'b0}};
                end else if (!in_range_s) begin
                    data_d = {WIDTH{1'b0}};
                end else if (BYPASS && wr_legal_s && (wr_addr == addr_s)) begin
                    data_d = wr_data;
                end else begin
                    data_d = mem_q[addr_s];
                end
            end else begin
                data_d  = data_q;
                valid_d = 1'b0;
            end
        end

        // Per-port output registers; reset drops any read in flight.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= {WIDTH{1'b0}};
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = data_q;
        assign rd_valid[i]               = valid_q;
    end

endmodule
